// File: rtl/mc_control_fsm.sv
// Multi-cycle RV32I sequencing controller: walks fetch/decode/execute/memory/writeback
// and drives every datapath enable and mux select, with memory timeout and illegal-op halt.
module mc_control_fsm #(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             areset,
  input  logic [6:0]       opcode,
  input  logic             branch_taken,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             adr_src,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [3:0]       state,
  output logic             halted,
  output logic [CNT_W-1:0] instret
);

  localparam int unsigned WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BRANCH   = 4'd10,
    S_HALT     = 4'd11
  } state_t;

  state_t             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic               retire;
  logic               mem_wait;

  // State, sticky halt, retire counter and memory wait counter
  always_ff @(posedge clk) begin
    if (areset) begin
      state_q <= S_FETCH;
      halted  <= 1'b0;
      instret <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      halted  <= (state_d == S_HALT);
      wait_q  <= wait_d;
      if (retire) instret <= instret + CNT_W'(1);
    end
  end

  assign state = state_q;

  // Next state, Moore-decoded controls and wait/timeout bookkeeping
  always_comb begin
    state_d    = state_q;
    retire     = 1'b0;
    mem_wait   = 1'b0;
    wait_d     = '0;
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = 2'd0;
    alu_src_a  = 2'd0;
    alu_src_b  = 2'd0;
    alu_op     = 2'd0;

    case (state_q)
      S_FETCH: begin
        mem_wait   = 1'b1;
        alu_src_b  = 2'd2;
        result_src = 2'd2;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = 2'd1;
        alu_src_b = 2'd1;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECR;
          OP_ITYPE:     state_d = S_EXECI;
          OP_JAL:       state_d = S_JAL;
          OP_BRANCH:    state_d = S_BRANCH;
          default:      state_d = S_HALT;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'd2;
        alu_src_b = 2'd1;
        state_d   = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        mem_wait = 1'b1;
        adr_src  = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'd1;
        reg_write  = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_wait  = 1'b1;
        adr_src   = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXECR: begin
        alu_src_a = 2'd2;
        alu_op    = 2'd2;
        state_d   = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = 2'd2;
        alu_src_b = 2'd1;
        alu_op    = 2'd2;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_JAL: begin
        alu_src_a = 2'd1;
        alu_src_b = 2'd2;
        pc_write  = 1'b1;
        state_d   = S_ALUWB;
      end
      S_BRANCH: begin
        alu_src_a = 2'd2;
        alu_op    = 2'd1;
        pc_write  = branch_taken;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase

    // Memory wait timeout: the TIMEOUT-th consecutive not-ready cycle halts
    if (mem_wait && !mem_ready) begin
      if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
        state_d = S_HALT;
        retire  = 1'b0;
      end else begin
        wait_d = wait_q + WAIT_W'(1);
      end
    end
    if (state_d != state_q) wait_d = '0;

    if (areset) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Randomized scoreboard bench for mc_control_fsm: an instruction-level model expands each
// instruction into its expected per-cycle trace; a negedge monitor pops and compares.
module tb_mc_control_fsm;

  localparam int unsigned CNT_W   = 4;
  localparam int unsigned TIMEOUT = 15;

  localparam int FETCH = 0, DECODE = 1, MEMADR = 2, MEMREAD = 3, MEMWB = 4, MEMWRITE = 5;
  localparam int EXECR = 6, EXECI = 7, ALUWB = 8, JAL = 9, BRANCH = 10, HALT = 11;

  localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011, OP_JAL = 7'b1101111, OP_BR = 7'b1100011;

  logic             clk = 1'b0;
  logic             areset;
  logic [6:0]       opcode;
  logic             branch_taken;
  logic             mem_ready;
  logic             pc_write, adr_src, mem_write, ir_write, reg_write;
  logic [1:0]       result_src, alu_src_a, alu_src_b, alu_op;
  logic [3:0]       state;
  logic             halted;
  logic [CNT_W-1:0] instret;

  mc_control_fsm #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .areset(areset), .opcode(opcode), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write),
    .ir_write(ir_write), .reg_write(reg_write), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .state(state),
    .halted(halted), .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]       st;
    logic [12:0]      ctl;
    logic             hlt;
    logic [CNT_W-1:0] ir;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   errors  = 0;
  int   m_ir    = 0;
  bit   m_halt  = 1'b0;

  // Control bundle {pc_write,adr_src,mem_write,ir_write,reg_write,result_src,alu_src_a,alu_src_b,alu_op}
  function automatic logic [12:0] ctl_of(int st, bit mr, bit bt, bit rst);
    logic pcw = 0, adr = 0, mw = 0, irw = 0, rw = 0;
    logic [1:0] rs = 0, a = 0, b = 0, op = 0;
    case (st)
      FETCH:    begin b = 2; rs = 2; irw = mr; pcw = mr; end
      DECODE:   begin a = 1; b = 1; end
      MEMADR:   begin a = 2; b = 1; end
      MEMREAD:  adr = 1;
      MEMWB:    begin rs = 1; rw = 1; end
      MEMWRITE: begin adr = 1; mw = 1; end
      EXECR:    begin a = 2; op = 2; end
      EXECI:    begin a = 2; b = 1; op = 2; end
      ALUWB:    rw = 1;
      JAL:      begin a = 1; b = 2; pcw = 1; end
      BRANCH:   begin a = 2; op = 1; pcw = bt; end
      default:  ;
    endcase
    if (rst) begin pcw = 0; irw = 0; mw = 0; rw = 0; end
    return {pcw, adr, mw, irw, rw, rs, a, b, op};
  endfunction

  // One clock of stimulus plus the model's expectation for it
  task automatic step(input int st, input bit mr, input bit bt, input bit rst, input logic [6:0] opc);
    exp_t e;
    areset = rst; mem_ready = mr; branch_taken = bt; opcode = opc;
    e.st = 4'(st); e.ctl = ctl_of(st, mr, bt, rst); e.hlt = m_halt; e.ir = CNT_W'(m_ir);
    exp_q.push_back(e);
    @(posedge clk); #1;
  endtask

  // Memory wait phase: nw not-ready cycles then a ready one; res 0=done, 1=timed out, 2=reset
  task automatic wait_phase(input int st, input int nw, input int rst_at, input logic [6:0] opc,
                            output int res);
    res = 0;
    for (int k = 0; k <= nw; k++) begin
      if (k == rst_at) begin
        step(st, k == nw, $urandom_range(0, 1), 1'b1, opc);
        m_ir = 0; m_halt = 0; res = 2;
        return;
      end
      if (k < nw) begin
        step(st, 1'b0, $urandom_range(0, 1), 1'b0, opc);
        if (k + 1 == int'(TIMEOUT)) begin m_halt = 1; res = 1; return; end
      end else begin
        step(st, 1'b1, $urandom_range(0, 1), 1'b0, opc);
      end
    end
  endtask

  task automatic halt_seq(input int n, input logic [6:0] opc);
    for (int k = 0; k < n; k++) step(HALT, $urandom_range(0, 1), $urandom_range(0, 1), 1'b0, opc);
    step(HALT, $urandom_range(0, 1), $urandom_range(0, 1), 1'b1, opc);
    m_ir = 0; m_halt = 0;
  endtask

  task automatic retire_one();
    m_ir = (m_ir + 1) % (1 << CNT_W);
  endtask

  task automatic run_instr(input logic [6:0] opc, input bit bt, input int w0, input int w1,
                           input int r0, input int r1);
    int res;
    wait_phase(FETCH, w0, r0, opc, res);
    if (res == 1) begin halt_seq($urandom_range(3, 20), opc); return; end
    if (res == 2) return;
    step(DECODE, $urandom_range(0, 1), $urandom_range(0, 1), 1'b0, opc);
    case (opc)
      OP_LW: begin
        step(MEMADR, $urandom_range(0, 1), 1'b0, 1'b0, opc);
        wait_phase(MEMREAD, w1, r1, opc, res);
        if (res == 1) begin halt_seq($urandom_range(3, 20), opc); return; end
        if (res == 2) return;
        step(MEMWB, $urandom_range(0, 1), 1'b0, 1'b0, opc);
        retire_one();
      end
      OP_SW: begin
        step(MEMADR, $urandom_range(0, 1), 1'b0, 1'b0, opc);
        wait_phase(MEMWRITE, w1, r1, opc, res);
        if (res == 1) begin halt_seq($urandom_range(3, 20), opc); return; end
        if (res == 2) return;
        retire_one();
      end
      OP_R, OP_I: begin
        step((opc == OP_R) ? EXECR : EXECI, $urandom_range(0, 1), 1'b0, 1'b0, opc);
        step(ALUWB, $urandom_range(0, 1), 1'b0, 1'b0, opc);
        retire_one();
      end
      OP_JAL: begin
        step(JAL, $urandom_range(0, 1), 1'b0, 1'b0, opc);
        step(ALUWB, $urandom_range(0, 1), 1'b0, 1'b0, opc);
        retire_one();
      end
      OP_BR: begin
        step(BRANCH, $urandom_range(0, 1), bt, 1'b0, opc);
        retire_one();
      end
      default: begin
        m_halt = 1;
        halt_seq($urandom_range(3, 20), opc);
      end
    endcase
  endtask

  function automatic int rand_wait();
    int p = $urandom_range(0, 19);
    if (p < 12) return 0;
    if (p < 17) return $urandom_range(1, 4);
    return $urandom_range(TIMEOUT - 1, TIMEOUT + 1);
  endfunction

  // Monitor: every cycle the DUT presents outputs, compare against the next expectation
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (state !== e.st || halted !== e.hlt || instret !== e.ir ||
          {pc_write, adr_src, mem_write, ir_write, reg_write, result_src, alu_src_a,
           alu_src_b, alu_op} !== e.ctl) begin
        errors++;
        $display("FAIL cycle_check t=%0t: state=%0d halted=%b instret=%0d ctl=%b, required state=%0d halted=%b instret=%0d ctl=%b",
                 $time, state, halted, instret,
                 {pc_write, adr_src, mem_write, ir_write, reg_write, result_src, alu_src_a,
                  alu_src_b, alu_op}, e.st, e.hlt, e.ir, e.ctl);
      end
    end
  end

  initial begin
    logic [6:0] opc;
    logic [6:0] legal [6];
    legal[0] = OP_LW; legal[1] = OP_SW; legal[2] = OP_R;
    legal[3] = OP_I;  legal[4] = OP_JAL; legal[5] = OP_BR;

    areset = 1'b1; mem_ready = 1'b0; branch_taken = 1'b0; opcode = '0;
    @(posedge clk); @(posedge clk); #1;
    step(FETCH, 1'b0, 1'b0, 1'b1, OP_R);

    run_instr(OP_R, 1'b0, 0, 0, -1, -1);
    run_instr(OP_LW, 1'b0, 0, 3, -1, -1);
    run_instr(OP_BR, 1'b1, 0, 0, -1, -1);
    run_instr(OP_BR, 1'b0, 0, 0, -1, -1);
    run_instr(7'b1111111, 1'b0, 0, 0, -1, -1);
    run_instr(OP_JAL, 1'b0, 1, 0, -1, -1);
    run_instr(OP_SW, 1'b0, 0, 2, -1, 1);
    run_instr(OP_I, 1'b0, TIMEOUT - 1, 0, -1, -1);
    run_instr(OP_R, 1'b0, TIMEOUT, 0, -1, -1);
    run_instr(OP_LW, 1'b0, 0, TIMEOUT, -1, -1);
    for (int i = 0; i < 20; i++) run_instr(OP_R, 1'b0, 0, 0, -1, -1);

    for (int i = 0; i < 200; i++) begin
      int w0, w1, r0, r1;
      if ($urandom_range(0, 11) == 0) begin
        do opc = 7'($urandom); while (opc inside {OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BR});
      end else begin
        opc = legal[$urandom_range(0, 5)];
      end
      w0 = rand_wait(); w1 = rand_wait();
      r0 = ($urandom_range(0, 9) == 0) ? $urandom_range(0, w0) : -1;
      r1 = ($urandom_range(0, 9) == 0) ? $urandom_range(0, w1) : -1;
      run_instr(opc, $urandom_range(0, 1), w0, w1, r0, r1);
    end

    @(negedge clk); @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
